belt_warn_ctrl: RTL and testbench
=================================

Name: belt_warn_ctrl

Overview:
- Sequenced seat-belt warning controller for the cabin-alert path.
- Synchronises and debounces the key, passenger-present and belt switches.
- Raises a warning when key is on, a passenger is seated and the belt is open: grace delay, then a timed chime with blinking lamp, then a steady lamp until the condition clears.
- Drives the chime driver and dash lamp directly. Status code for the diagnostics bus.

Parameters:
- DEB_CYC, 4, consecutive stable cycles needed before a debounced input changes (>=1).
- GRACE_CYC, 1000, cycles in GRACE before the chime starts (>=1).
- CHIME_CYC, 5000, cycles the chime sounds (>=1).
- BLINK_HALF, 250, lamp half-period during CHIME, in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- key  in  1  ignition key on, asynchronous raw switch.
- pass  in  1  passenger seat occupied, asynchronous raw switch.
- belt  in  1  belt buckled, asynchronous raw switch.
- chime  out  1  chime enable, registered.
- lamp  out  1  warning lamp, registered.
- state_o  out  2  current state code, registered.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; chime=0, lamp=0, state_o=2'd0.
  - All sync flops, filtered values, timers and blink counter =0.
  - Reset asserted in any state forces these values immediately, without waiting for clk.
- Input path, per input:
  - 2-flop synchroniser, then debounce.
  - Mismatch counter increments while sync!=filt and clears when they are equal.
  - On the edge where the counter reaches DEB_CYC-1 with a mismatch still present: filt<=sync, counter<=0.
  - Raw-to-filt latency is 2+DEB_CYC edges. Pulses shorter than DEB_CYC cycles after sync are ignored.
- cond = key_f & pass_f & ~belt_f (combinational from filtered flops).
- States and codes: IDLE=0, GRACE=1, CHIME=2, LAMP=3.
  - IDLE: cond=1 -> GRACE, timer<=0.
  - GRACE: timer++ each cycle. cond=0 -> IDLE. timer==GRACE_CYC-1 -> CHIME, timer<=0, blink<=0.
  - CHIME: timer++. cond=0 -> IDLE. timer==CHIME_CYC-1 -> LAMP.
  - LAMP: hold. cond=0 -> IDLE.
  - cond=0 has priority over timer expiry in every state.
  - Re-entry after IDLE always restarts the full grace period; there is no resume.
- Outputs are registered, computed from next-state and updated on the same edge as the state register.
  - chime=1 exactly while in CHIME.
  - lamp=1 on entry to CHIME. It toggles when blink==BLINK_HALF-1, then blink<=0, so the pattern is BLINK_HALF high, BLINK_HALF low, and so on.
  - lamp=1 steady in LAMP. lamp=0 in IDLE and GRACE.
- Counter widths: $clog2 of the largest bound +1. No counter wraps, because each is cleared on its terminal value or on a state change.
- Latency from raw stimulus to IDLE->GRACE: 2+DEB_CYC+1 edges.

Decomposition:
- Shared package belt_pkg:
  - state typedef and codes (IDLE/GRACE/CHIME/LAMP = 0..3);
  - default timing constants.
- One sub-module, belt_debounce: synchroniser plus debounce, parameter DEB_CYC, ports clk, rst, d_raw, d_filt. Instantiated three times.
- The FSM, timer and blink logic stay in belt_warn_ctrl.

Test Plan (DEB_CYC=2, GRACE_CYC=8, CHIME_CYC=16, BLINK_HALF=2):
1. Reset release with key=1, pass=1, belt=0 already asserted -> state_o=1 at edge 5, state_o=2 and chime=1 at edge 13, state_o=3 at edge 29 with chime=0 and lamp=1 steady.
2. In CHIME -> lamp sequence 1,1,0,0,1,1,... over 16 cycles; chime high exactly 16 cycles.
3. One-cycle belt=1 pulse mid-GRACE -> ignored; CHIME entry edge unchanged.
4. belt held at 1 during CHIME -> chime=0, lamp=0 and state_o=0 exactly 2+2+1 edges after the raw change.
5. pass=0 during LAMP -> IDLE. pass back to 1 -> full 8-cycle GRACE again before chime.
6. rst asserted asynchronously mid-CHIME -> chime=0, lamp=0 and state_o=0 without a clk edge; on release with cond still true, scenario 1 timing repeats.

Source files
------------

// File: rtl/belt_pkg.sv
// rtl/belt_pkg.sv - shared state codes and default timing for the seat-belt warning path
package belt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRACE = 2'd1,
    ST_CHIME = 2'd2,
    ST_LAMP  = 2'd3
  } belt_state_e;

  localparam int DEF_DEB_CYC    = 4;
  localparam int DEF_GRACE_CYC  = 1000;
  localparam int DEF_CHIME_CYC  = 5000;
  localparam int DEF_BLINK_HALF = 250;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/belt_debounce.sv
// rtl/belt_debounce.sv - two-flop synchroniser plus mismatch-count debounce for one switch
module belt_debounce
  import belt_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic d_filt
);

  localparam int CW = $clog2(DEB_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Any cycle where the synced value agrees with the filter restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_raw;
      sync2_q <= sync1_q;
      if (sync2_q != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_q <= sync2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign d_filt = filt_q;

endmodule

// File: rtl/belt_warn_ctrl.sv
// rtl/belt_warn_ctrl.sv - seat-belt warning sequencer: grace delay, blinking chime, steady lamp
module belt_warn_ctrl
  import belt_pkg::*;
#(
  parameter int DEB_CYC    = DEF_DEB_CYC,
  parameter int GRACE_CYC  = DEF_GRACE_CYC,
  parameter int CHIME_CYC  = DEF_CHIME_CYC,
  parameter int BLINK_HALF = DEF_BLINK_HALF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic       pass,
  input  logic       belt,
  output logic       chime,
  output logic       lamp,
  output logic [1:0] state_o
);

  localparam int TW = $clog2(max2(GRACE_CYC, CHIME_CYC)) + 1;
  localparam int BW = $clog2(BLINK_HALF) + 1;
  localparam logic [TW-1:0] GRACE_LAST = TW'(GRACE_CYC - 1);
  localparam logic [TW-1:0] CHIME_LAST = TW'(CHIME_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic key_f, pass_f, belt_f, cond;

  belt_debounce #(.DEB_CYC(DEB_CYC)) u_deb_key  (.clk(clk), .rst(rst), .d_raw(key),  .d_filt(key_f));
  belt_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pass (.clk(clk), .rst(rst), .d_raw(pass), .d_filt(pass_f));
  belt_debounce #(.DEB_CYC(DEB_CYC)) u_deb_belt (.clk(clk), .rst(rst), .d_raw(belt), .d_filt(belt_f));

  assign cond = key_f & pass_f & ~belt_f;

  belt_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          chime_q, chime_d;
  logic          lamp_q, lamp_d;

  // A dropped condition wins over timer expiry, so every branch tests cond first.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    blink_d = blink_q;
    case (state_q)
      ST_IDLE: begin
        if (cond) begin
          state_d = ST_GRACE;
          timer_d = '0;
        end
      end
      ST_GRACE: begin
        if (!cond) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == GRACE_LAST) begin
          state_d = ST_CHIME;
          timer_d = '0;
          blink_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_CHIME: begin
        if (!cond) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == CHIME_LAST) begin
          state_d = ST_LAMP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
          blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
        end
      end
      ST_LAMP: begin
        if (!cond) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    chime_d = (state_d == ST_CHIME);
    lamp_d  = 1'b0;
    case (state_d)
      ST_CHIME: begin
        if (state_q != ST_CHIME) begin
          lamp_d = 1'b1;
        end else begin
          lamp_d = (blink_q == BLINK_LAST) ? ~lamp_q : lamp_q;
        end
      end
      ST_LAMP: lamp_d = 1'b1;
      default: lamp_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      blink_q <= '0;
      chime_q <= 1'b0;
      lamp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      chime_q <= chime_d;
      lamp_q  <= lamp_d;
    end
  end

  assign chime   = chime_q;
  assign lamp    = lamp_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_belt_warn_ctrl.sv
// tb/tb_belt_warn_ctrl.sv - vector table, corner sequences and random run against a run-length model
module tb_belt_warn_ctrl;

  localparam int DEB = 2;
  localparam int G   = 8;
  localparam int C   = 16;
  localparam int BH  = 2;

  logic       clk, rst, key, pass, belt;
  logic       chime, lamp;
  logic [1:0] state_o;

  belt_warn_ctrl #(.DEB_CYC(DEB), .GRACE_CYC(G), .CHIME_CYC(C), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .key(key), .pass(pass), .belt(belt),
    .chime(chime), .lamp(lamp), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       k, p, b;
    int         n;
    logic [1:0] st;
    logic       ch, lp;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: each input filters once DEB consecutive synced samples since its
  // last change disagree with it; the warning phase follows from how many
  // consecutive edges the condition has been true.
  logic        m_s1[3], m_s2[3], m_f[3];
  logic [31:0] m_hist[3];
  int          m_age[3];
  int          run;

  localparam logic [31:0] MASK = (32'd1 << DEB) - 32'd1;

  task automatic add(input logic k, input logic p, input logic b, input int n,
                     input logic [1:0] st, input logic ch, input logic lp);
    vec_t v;
    v.k = k; v.p = p; v.b = b; v.n = n; v.st = st; v.ch = ch; v.lp = lp;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: {state,chime,lamp} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_f[i] = 1'b0;
      m_hist[i] = '0; m_age[i] = 0;
    end
    run = 0;
  endtask

  task automatic model_edge(input logic rk, input logic rp, input logic rb);
    logic raw[3];
    raw[0] = rk; raw[1] = rp; raw[2] = rb;
    run = (m_f[0] & m_f[1] & ~m_f[2]) ? run + 1 : 0;
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][30:0], m_s2[i]};
      m_age[i]++;
      if (m_age[i] >= DEB && (m_hist[i] & MASK) == (m_f[i] ? 32'd0 : MASK)) begin
        m_f[i]   = m_s2[i];
        m_age[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  function automatic logic [3:0] exp_out(input int r);
    int k;
    if (r == 0) return 4'b0000;
    if (r <= G) return {2'd1, 1'b0, 1'b0};
    if (r <= G + C) begin
      k = r - G - 1;
      return {2'd2, 1'b1, ((k / BH) % 2 == 0) ? 1'b1 : 1'b0};
    end
    return {2'd3, 1'b0, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(key, pass, belt);
    #2;
    check("model", {state_o, chime, lamp}, exp_out(run));
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      key = vq[i].k; pass = vq[i].p; belt = vq[i].b;
      repeat (vq[i].n) tick();
      check($sformatf("vec%0d", i), {state_o, chime, lamp}, {vq[i].st, vq[i].ch, vq[i].lp});
    end
  endtask

  initial begin
    // scenario from reset: grace at edge 5, chime at 13, lamp at 29
    add(1,1,0, 4, 2'd0,0,0); add(1,1,0, 1, 2'd1,0,0); add(1,1,0, 7, 2'd1,0,0);
    add(1,1,0, 1, 2'd2,1,1); add(1,1,0, 1, 2'd2,1,1); add(1,1,0, 1, 2'd2,1,0);
    add(1,1,0, 1, 2'd2,1,0); add(1,1,0, 1, 2'd2,1,1); add(1,1,0,11, 2'd2,1,0);
    add(1,1,0, 1, 2'd3,0,1); add(1,1,0, 5, 2'd3,0,1);
    // passenger leaves during lamp, returns: full grace again
    add(1,0,0, 4, 2'd3,0,1); add(1,0,0, 1, 2'd0,0,0); add(1,1,0, 4, 2'd0,0,0);
    add(1,1,0, 1, 2'd1,0,0); add(1,1,0, 7, 2'd1,0,0); add(1,1,0, 1, 2'd2,1,1);
    // belt buckled mid-chime: idle exactly five edges later
    add(1,1,1, 4, 2'd2,1,1); add(1,1,1, 1, 2'd0,0,0);
    // belt opened again, then a one-cycle buckle glitch mid-grace
    add(1,1,0, 4, 2'd0,0,0); add(1,1,0, 1, 2'd1,0,0); add(1,1,0, 2, 2'd1,0,0);
    add(1,1,1, 1, 2'd1,0,0); add(1,1,0, 4, 2'd1,0,0); add(1,1,0, 1, 2'd2,1,1);

    rst = 1'b1; key = 1'b1; pass = 1'b1; belt = 1'b0;
    #12;
    model_reset();
    check("reset_state", {state_o, chime, lamp}, 4'b0000);
    #1 rst = 1'b0;

    apply_rows(0, 24);

    // async reset while chiming, no clock edge in between
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_mid_chime", {state_o, chime, lamp}, 4'b0000);
    #1 rst = 1'b0;
    apply_rows(0, 10);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) == 0) key  = ~key;
      if ($urandom_range(0, 79) == 0) pass = ~pass;
      if ($urandom_range(0, 59) == 0) belt = ~belt;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_random", {state_o, chime, lamp}, 4'b0000);
        rst = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
